// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   Operand-issue and result-capture stage wrapped around the combinational
//   alu. Requests are buffered in a small command FIFO and issued one at a
//   time onto the ALU inputs. Each result is captured into a holding register
//   with a valid/ready handshake. A carry flag lets multi-word add/subtract
//   sequences chain through Cin.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   in_valid / in_ready             request handshake (in_ready = FIFO not full)
//   in_a, in_b, in_card, in_cin     request operands, opcode, explicit carry-in
//   in_use_carry                    take Cin from carry_flag instead of in_cin
//   alu_a, alu_b, alu_card, alu_cin operands driven to the alu
//   alu_f, alu_cout, alu_zero       results coming back from the alu
//   out_valid / out_ready           result handshake
//   out_f, out_cout, out_zero       captured result
//   carry_flag                      Cout of the last captured result
//
// Configuration
//   ALU_ISSUE_CARRY_CHAIN_EN  when defined, in_use_carry is honoured and
//                             carry_flag is a live register; otherwise
//                             in_use_carry is ignored and carry_flag is 0.

module alu_issue_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [4:0]       in_card,
  input  logic             in_cin,
  input  logic             in_use_carry,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_card,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             out_cout,
  output logic             out_zero,
  output logic             carry_flag
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t state;

  // Command FIFO storage, one array per field.
  logic [WIDTH-1:0] mem_a    [DEPTH];
  logic [WIDTH-1:0] mem_b    [DEPTH];
  logic [4:0]       mem_card [DEPTH];
  logic             mem_cin  [DEPTH];
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
  logic             mem_use  [DEPTH];
  logic             use_q;
  logic             carry_q;
`else
  logic             unused_use_carry;
`endif

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [4:0]       card_q;
  logic             cin_q;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  // A pop happens whenever the operand registers are free to take the next
  // request: from IDLE, or from HOLD on the edge the result is consumed.
  assign pop = !empty && ((state == IDLE) || ((state == HOLD) && out_ready));

  // FIFO storage is written without reset; entries are only read once a
  // push has made them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wptr[AW-1:0]]    <= in_a;
      mem_b[wptr[AW-1:0]]    <= in_b;
      mem_card[wptr[AW-1:0]] <= in_card;
      mem_cin[wptr[AW-1:0]]  <= in_cin;
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
      mem_use[wptr[AW-1:0]]  <= in_use_carry;
`endif
    end
  end

  // Pointers, operand registers, result holding register and the FSM.
  // Operand registers only change on a pop, so the alu inputs stay stable
  // while a result is being held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      card_q    <= '0;
      cin_q     <= 1'b0;
      out_valid <= 1'b0;
      out_f     <= '0;
      out_cout  <= 1'b0;
      out_zero  <= 1'b0;
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
      use_q     <= 1'b0;
      carry_q   <= 1'b0;
`endif
    end else begin
      if (push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop) begin
        rptr   <= rptr + {{AW{1'b0}}, 1'b1};
        a_q    <= mem_a[rptr[AW-1:0]];
        b_q    <= mem_b[rptr[AW-1:0]];
        card_q <= mem_card[rptr[AW-1:0]];
        cin_q  <= mem_cin[rptr[AW-1:0]];
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
        use_q  <= mem_use[rptr[AW-1:0]];
`endif
      end

      case (state)
        IDLE: begin
          if (!empty) state <= EXEC;
        end
        EXEC: begin
          out_f     <= alu_f;
          out_cout  <= alu_cout;
          out_zero  <= alu_zero;
          out_valid <= 1'b1;
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
          carry_q   <= alu_cout;
`endif
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= empty ? IDLE : EXEC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_card = card_q;

`ifdef ALU_ISSUE_CARRY_CHAIN_EN
  // carry_flag only updates at the end of EXEC, so during EXEC it still holds
  // the previous op's Cout, which is what a chained op must see.
  assign alu_cin    = use_q ? carry_q : cin_q;
  assign carry_flag = carry_q;
`else
  assign alu_cin          = cin_q;
  assign carry_flag       = 1'b0;
  assign unused_use_carry = in_use_carry;
`endif

endmodule
